vec_instr_issue: RTL and testbench

//  Instruction issue stage directly upstream of the vector CPU core. Accepts 9-bit vector

---
 rtl/vec_instr_issue_pkg.sv | 45 ++++
 rtl/vec_instr_issue_if.sv | 35 +++
 rtl/vec_instr_issue_fifo.sv | 80 ++++++++
 rtl/vec_instr_issue.sv | 131 +++++++++++++
 tb/tb_vec_instr_issue.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_instr_issue_pkg.sv
// vec_isa_pkg
//  Shared definitions for the vector instruction issue stage: the 9-bit
//  instruction encoding, its field positions and the legality screen that
//  decides whether an incoming word may be forwarded to the CPU.
//  Encoding: [8:7] op, [6:5] register, [4:0] memory block index (addr = idx*16).
//  No ports (package).
package vec_isa_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 7;
    localparam int REG_MSB = 6;
    localparam int REG_LSB = 5;
    localparam int IDX_MSB = 4;

    typedef logic [INSTR_W-1:0] vec_instr_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_ADD   = 2'b10,
        OP_MUL   = 2'b11
    } vec_op_e;

    typedef enum logic [1:0] {
        REG_A1 = 2'b00,
        REG_A2 = 2'b01,
        REG_A3 = 2'b10,
        REG_A4 = 2'b11
    } vec_reg_e;

    // LOAD may only target A1/A2, STORE only A3/A4; arithmetic ops carry no
    // operands, so their register and index fields must be zero.
    function automatic logic is_legal(input vec_instr_t instr);
        logic legal;
        case (vec_op_e'(instr[OP_MSB:OP_LSB]))
            OP_LOAD:  legal = !instr[REG_MSB];
            OP_STORE: legal = instr[REG_MSB];
            default:  legal = (instr[REG_MSB:REG_LSB] == 2'b00) &&
                              (instr[IDX_MSB:0] == '0);
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/vec_instr_issue_if.sv
// vec_instr_issue_if
//  Bundle of the host-side handshake and the CPU-side instruction bus of the
//  issue stage.
//  Signals:
//   in_valid/in_instr/in_ready  host offers an instruction, stage accepts
//   flush                        discard queued and in-flight instructions
//   instr/instr_valid            instruction held on the CPU bus
//   busy/err/issued_count        status towards the host
//  Modports: master = host/CPU side, slave = issue stage.
interface vec_instr_issue_if #(
    parameter int CNT_W = 16
);
    import vec_isa_pkg::*;

    logic             in_valid;
    vec_instr_t       in_instr;
    logic             in_ready;
    logic             flush;
    vec_instr_t       instr;
    logic             instr_valid;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] issued_count;

    modport master (
        output in_valid, in_instr, flush,
        input  in_ready, instr, instr_valid, busy, err, issued_count
    );

    modport slave (
        input  in_valid, in_instr, flush,
        output in_ready, instr, instr_valid, busy, err, issued_count
    );

endinterface

// File: rtl/vec_instr_issue_fifo.sv
// vec_instr_fifo
//  Synchronous FIFO of DEPTH entries, WIDTH bits each, with first-word
//  fall-through read data and a synchronous flush that has priority over
//  push and pop.
//  Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   flush_i           empty the FIFO at the next edge
//   data_o            head entry
//   full_o, empty_o   occupancy flags from the registered count
//   count_o           number of stored entries (log2(DEPTH)+1 bits)
module vec_instr_fifo
    import vec_isa_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vec_instr_issue.sv
// vec_instr_issue
//  Issue stage in front of the vector CPU core. Screens incoming instructions,
//  queues legal ones and drives each onto the CPU bus for HOLD_CYCLES clocks,
//  back to back while work is queued.
//  Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vec_instr_issue_if.slave: in_valid/in_instr/in_ready handshake,
//          flush, instr/instr_valid CPU bus, busy, err pulse, issued_count
module vec_instr_issue
    import vec_isa_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst_n,
    vec_instr_issue_if.slave bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]          state_q,       state_d;
    logic [HOLD_W-1:0]   holdCnt_q,     holdCnt_d;
    vec_instr_t          instr_q,       instr_d;
    logic [CNT_W-1:0]    issuedCount_q, issuedCount_d;
    logic                err_q,         err_d;

    logic                accept;
    logic                instrLegal;
    logic                fifoPush;
    logic                fifoPop;
    vec_instr_t          fifoHead;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [$clog2(DEPTH):0] fifoCount;

    vec_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .data_i  (bus.in_instr),
        .pop_i   (fifoPop),
        .flush_i (bus.flush),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Ready comes only from the registered occupancy, so a pop in the same
    // cycle never frees a slot for a push. Illegal words still complete the
    // handshake; they are simply not stored and flagged on err.
    assign accept     = bus.in_valid && !fifoFull && !bus.flush;
    assign instrLegal = is_legal(bus.in_instr);
    assign fifoPush   = accept && instrLegal;
    assign err_d      = accept && !instrLegal;

    always_comb begin
        state_d       = state_q;
        holdCnt_d     = holdCnt_q;
        instr_d       = instr_q;
        issuedCount_d = issuedCount_q;
        fifoPop       = 1'b0;
        if (bus.flush) begin
            // An instruction whose hold ends on the flush edge is not counted.
            state_d       = ST_IDLE;
            holdCnt_d     = '0;
            issuedCount_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fifoPop = !fifoEmpty;
                end
                ST_ISSUE: begin
                    if (holdCnt_q != '0) begin
                        holdCnt_d = holdCnt_q - 1'b1;
                    end else begin
                        issuedCount_d = issuedCount_q + 1'b1;
                        if (!fifoEmpty) begin
                            fifoPop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            // instr_q is only loaded on a pop, so it keeps its last value in IDLE.
            if (fifoPop) begin
                instr_d   = fifoHead;
                holdCnt_d = HOLD_LAST;
                state_d   = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            holdCnt_q     <= '0;
            instr_q       <= '0;
            issuedCount_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdCnt_q     <= holdCnt_d;
            instr_q       <= instr_d;
            issuedCount_q <= issuedCount_d;
            err_q         <= err_d;
        end
    end

    assign bus.in_ready     = !fifoFull;
    assign bus.instr        = instr_q;
    assign bus.instr_valid  = (state_q == ST_ISSUE);
    assign bus.busy         = (fifoCount != '0) || (state_q == ST_ISSUE);
    assign bus.err          = err_q;
    assign bus.issued_count = issuedCount_q;

endmodule

// File: tb/tb_vec_instr_issue.sv
// tb_vec_instr_issue
//  Self-checking bench for vec_instr_issue. A scoreboard queue receives every
//  legal instruction at its handshake edge; a monitor pops and compares each
//  one when it appears on the CPU bus and tracks hold length, err pulses,
//  issued_count, in_ready and busy. A second instance with HOLD_CYCLES=1
//  covers single-cycle issue.
module tb_vec_instr_issue;
    import vec_isa_pkg::*;

    localparam int DEPTH = 8;
    localparam int HOLD  = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vec_instr_issue_if #(.CNT_W(CNT_W)) bus  ();
    vec_instr_issue_if #(.CNT_W(CNT_W)) bus1 ();

    vec_instr_issue #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_instr_issue #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (1),
        .CNT_W       (CNT_W)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard and reference state for the HOLD=2 instance.
    vec_instr_t expQ[$];
    vec_instr_t lastExp;
    int         holdPos;
    int         issuedExp;
    bit         issueDue;
    bit         errNext;
    int         errSeen;
    bit         sawNotReady;

    vec_instr_t exp1[$];

    vec_instr_t prog2 [5] = '{9'h000, 9'h021, 9'h180, 9'h0C2, 9'h0E3};
    vec_instr_t prog5 [7] = '{9'h100, 9'h180, 9'h005, 9'h0C7, 9'h023, 9'h100, 9'h0E1};
    vec_instr_t prog6 [3] = '{9'h0C1, 9'h180, 9'h013};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic bit legalModel(input vec_instr_t v);
        if (v[8:7] == 2'b00) return v[6] == 1'b0;
        if (v[8:7] == 2'b01) return v[6] == 1'b1;
        return v[6:0] == 7'd0;
    endfunction

    task automatic resetModel();
        expQ.delete();
        lastExp   = '0;
        holdPos   = 0;
        issuedExp = 0;
        issueDue  = 1'b0;
        errNext   = 1'b0;
    endtask

    // Handshakes are observed at the rising edge, outputs at the falling edge.
    task automatic monitorMain();
        bit expValid;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                resetModel();
            end else if (bus.flush) begin
                expQ.delete();
                holdPos   = 0;
                issueDue  = 1'b0;
                issuedExp = 0;
                errNext   = 1'b0;
            end else begin
                errNext = 1'b0;
                if (bus.in_valid && bus.in_ready) begin
                    if (legalModel(bus.in_instr)) expQ.push_back(bus.in_instr);
                    else errNext = 1'b1;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                resetModel();
            end else begin
                expValid = (holdPos != 0) || issueDue;
                checkOutput("instr_valid", 32'(bus.instr_valid), 32'(expValid));
                checkOutput("issued_count", 32'(bus.issued_count), 32'(issuedExp));
                checkOutput("err", 32'(bus.err), 32'(errNext));
                if (bus.err) errSeen++;
                if (expValid) begin
                    if (holdPos == 0) lastExp = expQ.pop_front();
                    checkOutput("instr", 32'(bus.instr), 32'(lastExp));
                    holdPos++;
                    if (holdPos == HOLD) begin
                        holdPos = 0;
                        issuedExp++;
                    end
                end else begin
                    checkOutput("instr_idle", 32'(bus.instr), 32'(lastExp));
                end
                checkOutput("in_ready", 32'(bus.in_ready), 32'(expQ.size() != DEPTH));
                checkOutput("busy", 32'(bus.busy), 32'((expQ.size() != 0) || expValid));
                if (!bus.in_ready) sawNotReady = 1'b1;
                issueDue = (expQ.size() != 0) && (holdPos == 0);
            end
        end
    endtask

    // Offers one instruction and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input vec_instr_t v);
        int n    = 0;
        bit took = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = v;
        while (!took && n < 50) begin
            @(posedge clk);
            n++;
            took = bus.in_ready;
        end
        checkOutput("acceptTimeout", 32'(took), 32'd1);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        checkOutput("idleTimeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_instr_t v;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_instr = '0;
        bus1.flush    = 1'b0;
        resetModel();
        errSeen     = 0;
        sawNotReady = 1'b0;
        fork
            monitorMain();
        join_none

        // Reset values while reset is held.
        #12;
        checkOutput("rst_instr", 32'(bus.instr), 32'h000);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_issued_count", 32'(bus.issued_count), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] MUL program, back-to-back");
        foreach (prog2[i]) applyStimulus(prog2[i]);
        waitIdle();
        checkOutput("t2_issued_count", 32'(bus.issued_count), 32'd5);
        checkOutput("t2_instr_last", 32'(bus.instr), 32'h0E3);
        checkOutput("t2_instr_valid", 32'(bus.instr_valid), 32'd0);

        $display("[TB] illegal encodings");
        errSeen = 0;
        applyStimulus(9'h040);
        applyStimulus(9'h101);
        repeat (3) @(negedge clk);
        checkOutput("t3_err_pulses", 32'(errSeen), 32'd2);
        checkOutput("t3_issued_count", 32'(bus.issued_count), 32'd5);
        checkOutput("t3_instr", 32'(bus.instr), 32'h0E3);

        // Sixteen offers outrun the one-per-two-cycles drain and fill the FIFO.
        $display("[TB] FIFO full");
        sawNotReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = (i % 2 == 1) ? (9'h0C0 | 9'(i)) : 9'(i);
            applyStimulus(v);
        end
        waitIdle();
        checkOutput("t4_saw_full", 32'(sawNotReady), 32'd1);
        checkOutput("t4_issued_count", 32'(bus.issued_count), 32'd21);

        // Three issued, third in its final hold cycle, four queued.
        $display("[TB] flush");
        foreach (prog5[i]) applyStimulus(prog5[i]);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 9'h0C5;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_issued_count", 32'(bus.issued_count), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("t5_no_late_issue", 32'(bus.instr_valid), 32'd0);

        $display("[TB] reset during hold");
        applyStimulus(9'h180);
        applyStimulus(9'h021);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_instr", 32'(bus.instr), 32'h000);
        checkOutput("t1_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("t1_busy", 32'(bus.busy), 32'd0);
        checkOutput("t1_err", 32'(bus.err), 32'd0);
        checkOutput("t1_issued_count", 32'(bus.issued_count), 32'd0);
        checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t1_abandoned", 32'(bus.instr_valid), 32'd0);

        $display("[TB] single-cycle hold instance");
        @(posedge clk);
        #1;
        fork
            begin
                foreach (prog6[i]) begin
                    bus1.in_valid = 1'b1;
                    bus1.in_instr = prog6[i];
                    @(posedge clk);
                    checkOutput("t6_in_ready", 32'(bus1.in_ready), 32'd1);
                    exp1.push_back(prog6[i]);
                    #1;
                end
                bus1.in_valid = 1'b0;
            end
            begin
                int firstIdx = -1;
                int lastIdx  = -1;
                int seen     = 0;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    if (bus1.instr_valid) begin
                        if (exp1.size() != 0)
                            checkOutput("t6_instr", 32'(bus1.instr), 32'(exp1.pop_front()));
                        else
                            checkOutput("t6_unexpected_issue", 32'(bus1.instr_valid), 32'd0);
                        if (firstIdx < 0) firstIdx = c;
                        lastIdx = c;
                        seen++;
                    end
                end
                checkOutput("t6_valid_cycles", 32'(seen), 32'd3);
                checkOutput("t6_consecutive", 32'(lastIdx - firstIdx + 1), 32'd3);
                checkOutput("t6_issued_count", 32'(bus1.issued_count), 32'd3);
                checkOutput("t6_instr_last", 32'(bus1.instr), 32'h013);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
